simd_alu_pipe: RTL and testbench

Parametrised, pipelined SIMD integer ALU. It is the next generation of the combinational 4×32-bit lane ALU in the execute stage. Lane count and lane width are configurable, the op set adds signed, saturating and compare operations, and a valid/ready handshake lets it sit between the vector issue queue and writeback with full backpressure. Latency is two registered stages; throughput is one operation per cycle.

---
 rtl/simd_alu_pkg.sv | 31 +++
 rtl/simd_lane_alu.sv | 67 ++++++
 rtl/simd_alu_pipe.sv | 91 +++++++++
 tb/tb_simd_alu_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
// Shared definitions for the SIMD ALU: opcode encoding and reserved-op range.
package simd_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MIN   = 4'd10,
        OP_MAX   = 4'd11,
        OP_ADDS  = 4'd12,
        OP_SUBS  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    // Opcodes in this inclusive range produce an all-zero result.
    localparam logic [3:0] OP_RSV_LO = 4'd14;
    localparam logic [3:0] OP_RSV_HI = 4'd15;

    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= OP_RSV_LO) && (op <= OP_RSV_HI);
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One combinational lane of the SIMD ALU: result and zero flag for LANE_W bits.
module simd_lane_alu
    import simd_alu_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  alu_op_e           op,
    output logic [LANE_W-1:0] result,
    output logic              zero
);

    localparam int SH_W = $clog2(LANE_W);
    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

    logic [SH_W-1:0] shamt;
    logic [LANE_W:0] sum_ext;
    logic [LANE_W:0] diff_ext;
    logic            lt_s;
    logic            lt_u;

    // Only the low log2(LANE_W) bits of b select the shift distance.
    assign shamt = b[SH_W-1:0];

    // One extra sign bit makes signed overflow visible as a mismatch of the top two bits.
    assign sum_ext  = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    assign diff_ext = {a[LANE_W-1], a} - {b[LANE_W-1], b};
    assign lt_s     = $signed(a) < $signed(b);
    assign lt_u     = a < b;

    // Opcode decode; default keeps reserved opcodes at zero and avoids latches.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum_ext[LANE_W-1:0];
            OP_SUB:  result = diff_ext[LANE_W-1:0];
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_SLT:  result = {{(LANE_W-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(LANE_W-1){1'b0}}, lt_u};
            OP_MIN:  result = lt_s ? a : b;
            OP_MAX:  result = lt_s ? b : a;
            OP_ADDS: begin
                if (sum_ext[LANE_W] != sum_ext[LANE_W-1])
                    result = sum_ext[LANE_W] ? SMIN : SMAX;
                else
                    result = sum_ext[LANE_W-1:0];
            end
            OP_SUBS: begin
                if (diff_ext[LANE_W] != diff_ext[LANE_W-1])
                    result = diff_ext[LANE_W] ? SMIN : SMAX;
                else
                    result = diff_ext[LANE_W-1:0];
            end
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU with valid/ready handshake on both sides.
module simd_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_a,
    input  logic [LANES*LANE_W-1:0] in_b,
    input  logic [3:0]              in_op,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_result,
    output logic [LANES-1:0]        out_zero_mask,
    output logic                    out_zero,
    output logic [TAG_W-1:0]        out_tag
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; a producer holding valid must keep its payload steady until it transfers,
    // and ready may depend combinationally on the downstream ready.

    logic                    s1_valid;
    logic [LANES*LANE_W-1:0] s1_a;
    logic [LANES*LANE_W-1:0] s1_b;
    alu_op_e                 s1_op;
    logic [TAG_W-1:0]        s1_tag;
    logic                    s2_valid;
    logic                    s2_can_load;
    logic [LANES*LANE_W-1:0] lane_result;
    logic [LANES-1:0]        lane_zero;

    assign s2_can_load = !s2_valid || out_ready;
    assign in_ready    = !s1_valid || s2_can_load;

    // Stage 1: capture operands on acceptance; payload holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_op  <= alu_op_e'(in_op);
                s1_tag <= in_tag;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane_alu #(.LANE_W(LANE_W)) u_lane (
            .a      (s1_a[i*LANE_W +: LANE_W]),
            .b      (s1_b[i*LANE_W +: LANE_W]),
            .op     (s1_op),
            .result (lane_result[i*LANE_W +: LANE_W]),
            .zero   (lane_zero[i])
        );
    end

    // Stage 2: register lane results; frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            out_result    <= '0;
            out_zero_mask <= '1;
            out_tag       <= '0;
        end else if (s2_can_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= lane_result;
                out_zero_mask <= lane_zero;
                out_tag       <= s1_tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_zero  = out_zero_mask[0];

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe with a behavioural lane reference model.
module tb_simd_alu_pipe;
  import simd_alu_pkg::*;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int TAG_W  = 4;
  localparam int DW     = LANES * LANE_W;
  localparam int W      = DW + LANES + TAG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_a = '0;
  logic [DW-1:0]    in_b = '0;
  logic [3:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_result;
  logic [LANES-1:0] out_zero_mask;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  simd_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_op         (in_op),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero_mask (out_zero_mask),
    .out_zero      (out_zero),
    .out_tag       (out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int acc_cyc_q[$];
  int pop_cyc_q[$];
  bit stream_mode = 0;
  bit bp_done = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [LANE_W-1:0] ref_lane(input logic [3:0] op,
                                                 input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
    longint sa, sb, s;
    int sh;
    longint smax, smin;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % LANE_W);
    smax = (longint'(1) <<< (LANE_W - 1)) - 1;
    smin = -(longint'(1) <<< (LANE_W - 1));
    if (is_reserved(op)) return '0;
    case (alu_op_e'(op))
      OP_ADD:  return LANE_W'(sa + sb);
      OP_SUB:  return LANE_W'(sa - sb);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return LANE_W'(a * (longint'(1) <<< sh));
      OP_SRL:  return LANE_W'(longint'(a) / (longint'(1) <<< sh));
      OP_SRA:  return LANE_W'(sa >>> sh);
      OP_SLT:  return (sa < sb) ? 1 : 0;
      OP_SLTU: return (longint'(a) < longint'(b)) ? 1 : 0;
      OP_MIN:  return (sa < sb) ? a : b;
      OP_MAX:  return (sa > sb) ? a : b;
      OP_ADDS: begin
        s = sa + sb;
        if (s > smax) s = smax;
        if (s < smin) s = smin;
        return LANE_W'(s);
      end
      OP_SUBS: begin
        s = sa - sb;
        if (s > smax) s = smax;
        if (s < smin) s = smin;
        return LANE_W'(s);
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_vec(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*LANE_W +: LANE_W] = ref_lane(op, a[i*LANE_W +: LANE_W], b[i*LANE_W +: LANE_W]);
    return r;
  endfunction

  function automatic logic [LANES-1:0] mask_of(input logic [DW-1:0] r);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (r[i*LANE_W +: LANE_W] == 0);
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [DW-1:0] exp_res);
    bit accepted = 0;
    int n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    while (!accepted && n < 1000) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        exp_q.push_back({exp_res, mask_of(exp_res), tag});
        if (stream_mode) acc_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) chk("accept_timeout", DW'(0), DW'(1));
    // Junk on idle inputs must not be captured.
    in_valid = 1'b0;
    in_a = rand_vec();
    in_b = rand_vec();
    in_op = 4'($urandom_range(0, 15));
    in_tag = TAG_W'($urandom);
  endtask

  task automatic issue_model(input logic [3:0] op, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
    issue(op, a, b, tag, ref_vec(op, a, b));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tagname);
    chk({tagname, "_out_valid"}, DW'(out_valid), DW'(0));
    chk({tagname, "_in_ready"}, DW'(in_ready), DW'(1));
    chk({tagname, "_out_result"}, out_result, DW'(0));
    chk({tagname, "_zero_mask"}, DW'(out_zero_mask), DW'(4'b1111));
    chk({tagname, "_out_zero"}, DW'(out_zero), DW'(1));
    chk({tagname, "_out_tag"}, DW'(out_tag), DW'(0));
  endtask

  // ---------------- monitor ----------------
  bit prev_stall = 0;
  logic [W:0] prev_out;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W:0] cur;
    cur = {out_valid, out_result, out_zero_mask, out_tag};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_stable", DW'(cur), DW'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_tag", DW'(out_tag), DW'({TAG_W{1'bx}}));
        end else begin
          e = exp_q.pop_front();
          chk("result", out_result, e[W-1 -: DW]);
          chk("zero_mask", DW'(out_zero_mask), DW'(e[TAG_W +: LANES]));
          chk("out_zero", DW'(out_zero), DW'(e[TAG_W]));
          chk("tag", DW'(out_tag), DW'(e[TAG_W-1:0]));
          if (stream_mode) pop_cyc_q.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = cur;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] va, vb, sa, sb;
    va = {32'h7FFFFFFF, 32'h80000000, 32'h00000005, 32'hFFFFFFFF};
    vb = {32'h00000001, 32'h00000001, 32'h00000003, 32'h00000001};
    sa = {4{32'h80000000}};
    sb = {4{32'h00000021}};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived results.
    issue(OP_ADDS, va, vb, 4'd1, {32'h7FFFFFFF, 32'h80000001, 32'h00000008, 32'h00000000});
    issue(OP_SUBS, va, vb, 4'd2, {32'h7FFFFFFE, 32'h80000000, 32'h00000002, 32'hFFFFFFFE});
    issue(OP_ADD,  va, vb, 4'd3, {32'h80000000, 32'h80000001, 32'h00000008, 32'h00000000});
    issue(OP_SLT,  va, vb, 4'd4, {32'h0, 32'h1, 32'h0, 32'h1});
    issue(OP_SLTU, va, vb, 4'd5, {32'h0, 32'h0, 32'h0, 32'h0});
    issue(OP_SRA,  sa, sb, 4'd6, {4{32'hC0000000}});
    issue(OP_SRL,  sa, sb, 4'd7, {4{32'h40000000}});
    issue(4'd14, rand_vec(), rand_vec(), 4'd8, DW'(0));
    // Every opcode, including reserved, against the model.
    for (int op = 0; op < 16; op++) issue_model(4'(op), va, vb, 4'(op));
    drain();

    // Streaming: 16 back-to-back operations, consumer always ready.
    stream_mode = 1;
    for (int t = 0; t < 16; t++)
      issue_model(4'($urandom_range(0, 15)), rand_vec(), rand_vec(), 4'(t));
    drain();
    stream_mode = 0;
    if (acc_cyc_q.size() == 16 && pop_cyc_q.size() == 16) begin
      chk("first_latency", DW'(pop_cyc_q[0]), DW'(acc_cyc_q[0] + 2));
      for (int k = 1; k < 16; k++)
        chk("throughput", DW'(pop_cyc_q[k]), DW'(pop_cyc_q[0] + k));
    end else begin
      chk("stream_count", DW'(pop_cyc_q.size()), DW'(16));
    end

    // Backpressure: random consumer stalls over 200 operations.
    bp_done = 0;
    fork
      begin
        for (int t = 0; t < 200; t++)
          issue_model(4'($urandom_range(0, 15)), rand_vec(), rand_vec(), 4'(t));
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    issue_model(OP_XOR, rand_vec(), rand_vec(), 4'hA);
    issue_model(OP_OR, rand_vec(), rand_vec(), 4'hB);
    @(negedge clk);
    chk("both_full_in_ready", DW'(in_ready), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++)
      issue_model(4'($urandom_range(0, 13)), rand_vec(), rand_vec(), 4'(t + 2));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global safety bound on run length.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
